if_fetch_buf: RTL
=================

// Module: if_fetch_buf
// PURPOSE
//  Instruction fetch queue between the PC/instruction-ROM stage and decode. Captures
//  {pc, inst} pairs returned by the ROM into a DEPTH-entry circular FIFO and presents
//  them to ID with valid/ready. Branch flush discards all queued and incoming entries.
//  This decouples decode stalls from the free-running PC without losing fetched words.
// PARAMETERS
//  DEPTH      4           queue entries; power of two, >= 2
//  NOP_INST   32'h13      instruction driven on d_inst_o while d_valid_o = 0 (addi x0,x0,0)
// PORTS
//  clk         in   1    core clock, all state on posedge
//  rst         in   1    asynchronous, active-low reset (0 = reset)
//  flush_i     in   1    branch taken (branch_flag); clears queue
//  f_valid_i   in   1    fetch word valid this cycle
//  f_pc_i      in   32   PC of fetched word
//  f_inst_i    in   32   fetched instruction
//  f_ready_o   out  1    queue can accept; = (count != DEPTH)
//  d_valid_o   out  1    head entry valid for decode
//  d_pc_o      out  32   head PC
//  d_inst_o    out  32   head instruction
//  d_ready_i   in   1    decode consumes head this cycle
//  count_o     out  log2(DEPTH)+1   current occupancy
// BEHAVIOUR
//  - Reset (rst=0, async): wr_ptr=rd_ptr=0, count=0, d_valid_o=0, d_pc_o=0,
//    d_inst_o=NOP_INST, f_ready_o=1. Reset mid-operation drops all entries immediately.
//  - push = f_valid_i & f_ready_o & ~flush_i; pop = d_valid_o & d_ready_i & ~flush_i.
//  - Push writes {f_pc_i,f_inst_i} at wr_ptr; wr_ptr+1 mod DEPTH (wraps DEPTH-1 -> 0).
//  - Pop advances rd_ptr+1 mod DEPTH. Simultaneous push & pop: count unchanged.
//  - Full (count=DEPTH): f_ready_o=0; a pop the same cycle does NOT admit a push
//    (f_ready_o depends on count only, no combinational ready path).
//  - Empty (count=0): d_valid_o=0, d_pc_o=0, d_inst_o=NOP_INST (non-bypass case).
//  - Entries leave in strict FIFO order; no reordering, no duplication.
//  - Latency (no bypass): word pushed in cycle N is visible on d_* in cycle N+1.
//  - flush_i=1: next edge sets count=0, rd_ptr=wr_ptr=0, d_valid_o=0; f_valid_i and
//    d_ready_i in the flush cycle are ignored (flush has priority over push/pop).
//  - Flush in cycle N: first post-branch word may be pushed in cycle N+1.
//  - d_* outputs are driven from the head register array (combinational read of rd_ptr).
//  - count_o = number of valid entries, 0..DEPTH; never exceeds DEPTH, never underflows.
// CONFIGURATION
//  `IF_FETCH_BYPASS_EN defined: when count=0, f_valid_i=1, flush_i=0, d_valid_o is
//    asserted combinationally with d_pc_o/d_inst_o = f_pc_i/f_inst_i; if d_ready_i=1
//    the word is consumed and not written (count stays 0); if d_ready_i=0 it is pushed
//    normally. Zero-cycle latency through an empty queue.
//  Not defined: no combinational input->output path; minimum latency 1 cycle.
// TESTING
//  1 Reset: rst=0 async mid-cycle -> d_valid_o=0, d_inst_o=32'h13, count_o=0, f_ready_o=1.
//  2 Stream: push pc 0,4,8 with d_ready_i=1 -> d_pc_o 0,4,8 in order, 1-cycle latency
//    (0-cycle with IF_FETCH_BYPASS_EN), count_o never >1.
//  3 Fill: d_ready_i=0, push pc 0x0..0xC -> count_o=4, f_ready_o=0; 5th word 0x10 held
//    upstream; release d_ready_i -> outputs 0x0,0x4,0x8,0xC, then 0x10.
//  4 Wrap: 10 push/pop cycles with DEPTH=4 -> pointers wrap, order preserved, no loss.
//  5 Flush: 3 queued entries, flush_i=1 with f_valid_i=1 pc=0x20 -> next cycle count_o=0,
//    d_valid_o=0, 0x20 dropped; push pc 0x100 next -> first d_pc_o=0x100.
//  6 Full+pop: count=4, pop and f_valid_i same cycle -> count_o=3, incoming not accepted.

Source files
------------

// File: rtl/if_fetch_buf.sv
// if_fetch_buf: DEPTH-entry {pc,inst} fetch queue between instruction ROM and decode, with flush.
// Optional zero-latency path through an empty queue is enabled by defining IF_FETCH_BYPASS_EN.
module if_fetch_buf #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] NOP_INST = 32'h13
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush_i,
    input  logic                     f_valid_i,
    input  logic [31:0]              f_pc_i,
    input  logic [31:0]              f_inst_i,
    output logic                     f_ready_o,
    output logic                     d_valid_o,
    output logic [31:0]              d_pc_o,
    output logic [31:0]              d_inst_o,
    input  logic                     d_ready_i,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);
    logic [31:0]   pc_q [DEPTH];
    logic [31:0]   inst_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          empty, bypass, push, pop;
    assign empty     = count_q == '0;
    assign f_ready_o = count_q != (AW+1)'(DEPTH);
`ifdef IF_FETCH_BYPASS_EN
    assign bypass = empty & f_valid_i & ~flush_i;
`else
    assign bypass = 1'b0;
`endif
    assign d_valid_o = ~empty | bypass;
    assign d_pc_o    = bypass ? f_pc_i : empty ? 32'h0 : pc_q[rd_ptr_q];
    assign d_inst_o  = bypass ? f_inst_i : empty ? NOP_INST : inst_q[rd_ptr_q];
    assign count_o   = count_q;
    // A bypassed word that decode takes immediately is never written into the queue.
    assign pop  = ~empty & d_ready_i & ~flush_i;
    assign push = f_valid_i & f_ready_o & ~flush_i & ~(bypass & d_ready_i);
    always_comb begin
        wr_ptr_d = flush_i ? '0 : wr_ptr_q + AW'(push);
        rd_ptr_d = flush_i ? '0 : rd_ptr_q + AW'(pop);
        count_d  = flush_i ? '0 : count_q + (AW+1)'(push) - (AW+1)'(pop);
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
    always_ff @(posedge clk) begin
        if (push) begin
            pc_q[wr_ptr_q]   <= f_pc_i;
            inst_q[wr_ptr_q] <= f_inst_i;
        end
    end
endmodule
